chasy_setup: RTL
================

# chasy_setup

Time-setting controller for the real-time clock. It is the initiator side of the clock's `setup_data`/`setup_imp` load port. Three raw push-buttons let the user capture the running time, edit hours, minutes and seconds with wrap-around, and commit the result with a single-cycle load pulse. It sits between the board buttons and the clock, and also feeds field/blink hints to the display path.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable cycles needed to accept a button level (10 ms at 50 MHz).
- `BLINK_DIV`, default 25000000: cycles per `blink` half-period.
- `clock`  in  1: system clock, 50 MHz.
- `reset`  in  1: asynchronous, active-low.
- `btn_mode`, `btn_up`, `btn_down`  in  1 each: raw asynchronous buttons, active-high.
- `time_in`  in  24: running time, `[23:16]` hour, `[15:8]` min, `[7:0]` sec, all binary.
- `setup_data`  out  24: edit register, same field layout as `time_in`.
- `setup_imp`  out  1: one-cycle load strobe to the clock.
- `edit_active`  out  1: high while editing.
- `edit_field`  out  2: selected field; 0 = hour, 1 = min, 2 = sec.
- `blink`  out  1: blink enable for the selected field.

## Operation
- **Button conditioning** (per button):
  - 2-FF synchronizer.
  - Stability counter: the level is accepted only after `DEBOUNCE_CYCLES` consecutive equal samples.
  - A one-cycle press pulse is produced on each accepted 0→1 transition. Releases produce nothing. There is no auto-repeat.
- **FSM states:** IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT.
- **IDLE:**
  - On a mode pulse, capture `time_in` into the edit register and go to EDIT_HOUR.
  - Up/down pulses are ignored.
- **Capture clamping:** any captured field above its maximum is loaded as 0.
- **EDIT_x:**
  - An up pulse increments the field; a down pulse decrements it.
  - Hour wraps within 0..23. Minute and second wrap within 0..59, so 23+1→0 and 0−1→23.
  - A mode pulse advances EDIT_HOUR→EDIT_MIN→EDIT_SEC→COMMIT.
- **COMMIT:** lasts exactly one cycle, asserts `setup_imp`, then returns to IDLE.
- **`setup_data`:** always reflects the edit register. It holds the last committed value in IDLE.
- **Simultaneous events:**
  - Mode has priority over up/down in the same cycle; the up/down pulse is dropped.
  - Up and down in the same cycle cause no change.
- **Blink:**
  - A free-running toggle every `BLINK_DIV` cycles while `edit_active`.
  - Forced to 1 and its counter cleared on entry to any EDIT state.
  - 0 in IDLE and COMMIT.
- **`edit_field`:** 0/1/2 in EDIT_HOUR/MIN/SEC; 0 in IDLE and COMMIT.

## Timing
- **Reset values:** all outputs 0, FSM in IDLE, debounce counters 0, synchronized levels 0.
- **Reset mid-edit:** returns to IDLE immediately. No `setup_imp` is issued and `setup_data` becomes 0.
- **Button latency:** raw edge to press pulse is 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles.
- **Action latency:** state, field and `setup_data` update on the clock edge after the press pulse cycle.
- **Commit pulse:** `setup_imp` is registered. It is high only in the COMMIT cycle, which is the cycle after the EDIT_SEC mode pulse. `setup_data` is stable during that cycle and afterwards.
- **Glitch rejection:** a raw pulse shorter than `DEBOUNCE_CYCLES` cycles is never accepted.
- **Arithmetic:** performed per field at 8-bit width, using explicit compares against the maximum or 0. The design never relies on modulo or overflow.

## Structure
- **Package `chasy_pkg`:**
  - Constants `HOUR_MAX` = 23, `MIN_MAX` = 59, `SEC_MAX` = 59.
  - Field bit-slice constants.
  - FSM state enum `setup_state_t`.
  - Field index enum `field_t`.
- **Sub-module `btn_cond`:** synchronizer, debounce and rising-edge pulse, parameterised by `DEBOUNCE_CYCLES`, instantiated 3×.
- **Top level:** FSM, edit register with per-field wrap logic, and blink counter.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES` = 4, `BLINK_DIV` = 8.
- **Reset:** assert `reset`=0 with the buttons toggling → all outputs 0. Release → still IDLE, `setup_imp` never high.
- **Capture:** `time_in` = 0x0C1E2D (12:30:45), mode press held 10 cycles → `edit_active` = 1, `edit_field` = 0, `setup_data` = 0x0C1E2D, `blink` = 1. With `time_in` = 0x1E0000 → captured hour = 0.
- **Wrap:**
  - Hour 23 + up → 0.
  - Hour 0 + down → 23.
  - Minute 59 + up → 0.
  - Second 0 + down → 59.
- **Full edit and commit:** from 12:30:45, do mode, up ×2, mode, down, mode, mode → exactly one `setup_imp` cycle with `setup_data` = 0x0E1D2D. Then `edit_active` = 0 and `edit_field` = 0.
- **Glitch and simultaneity:**
  - A 2-cycle `btn_up` glitch → no change.
  - `btn_up` and `btn_down` pressed together → no change.
  - Mode and up in the same cycle → field advances, value unchanged.
- **Reset mid-edit:** in EDIT_MIN, pulse `reset` low → IDLE, `setup_data` = 0, no `setup_imp` at any point.

Source files
------------

// File: rtl/chasy_pkg.sv
// Shared constants, types and field arithmetic for the clock time-setting path.
package chasy_pkg;

    // Field width and positions inside the 24-bit {hour, min, sec} word
    localparam int FIELD_W  = 8;
    localparam int HOUR_LSB = 16;
    localparam int MIN_LSB  = 8;
    localparam int SEC_LSB  = 0;

    // Largest legal value of each field
    localparam logic [FIELD_W-1:0] HOUR_MAX = 8'd23;
    localparam logic [FIELD_W-1:0] MIN_MAX  = 8'd59;
    localparam logic [FIELD_W-1:0] SEC_MAX  = 8'd59;

    // Setup controller states
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_EDIT_HOUR = 3'd1,
        S_EDIT_MIN  = 3'd2,
        S_EDIT_SEC  = 3'd3,
        S_COMMIT    = 3'd4
    } setup_state_t;

    // Field index reported to the display path
    typedef enum logic [1:0] {
        F_HOUR = 2'd0,
        F_MIN  = 2'd1,
        F_SEC  = 2'd2
    } field_t;

    // Increment with wrap to zero at the field maximum (explicit compare, no modulo)
    function automatic logic [FIELD_W-1:0] inc_wrap(input logic [FIELD_W-1:0] v,
                                                    input logic [FIELD_W-1:0] max_v);
        logic [FIELD_W-1:0] r;
        if (v >= max_v) r = '0;
        else            r = v + 8'd1;
        return r;
    endfunction

    // Decrement with wrap from zero up to the field maximum
    function automatic logic [FIELD_W-1:0] dec_wrap(input logic [FIELD_W-1:0] v,
                                                    input logic [FIELD_W-1:0] max_v);
        logic [FIELD_W-1:0] r;
        if (v == '0)       r = max_v;
        else if (v > max_v) r = max_v;
        else               r = v - 8'd1;
        return r;
    endfunction

    // Out-of-range captured values are loaded as zero
    function automatic logic [FIELD_W-1:0] clamp_field(input logic [FIELD_W-1:0] v,
                                                       input logic [FIELD_W-1:0] max_v);
        logic [FIELD_W-1:0] r;
        if (v > max_v) r = '0;
        else           r = v;
        return r;
    endfunction

endpackage

// File: rtl/chasy_setup_btn_cond.sv
// Push-button conditioner: 2-FF synchronizer, stability debounce and a
// one-cycle pulse on each accepted press. Releases are debounced but silent.
module btn_cond #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    logic          w_differs;
    logic          w_accept;

    // The synchronized sample disagrees with the accepted level; the new level
    // is taken once DEBOUNCE_CYCLES such samples arrive back to back.
    assign w_differs = (r_sync2 != r_level);
    assign w_accept  = w_differs && (r_cnt == CNT_LAST);

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Stability counter: any sample equal to the current level restarts it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (!w_differs) begin
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
        end else begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // Registered press pulse on an accepted 0->1 level change only
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_press <= 1'b0;
        else        r_press <= w_accept && r_sync2;
    end

    assign press = r_press;

endmodule

// File: rtl/chasy_setup.sv
// Time-setting controller for the RTC: captures the running time, edits
// hour/min/sec with wrap-around and commits with a one-cycle load strobe.
module chasy_setup
    import chasy_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_DIV       = 25000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [23:0] time_in,
    output logic [23:0] setup_data,
    output logic        setup_imp,
    output logic        edit_active,
    output logic [1:0]  edit_field,
    output logic        blink,
    output logic [2:0]  dbg_state
);

    localparam int BW = (BLINK_DIV < 2) ? 1 : $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    // Button pulses
    logic w_mode_p;
    logic w_up_p;
    logic w_down_p;
    logic w_inc;
    logic w_dec;

    // FSM
    setup_state_t r_state;
    setup_state_t w_next_state;
    logic         w_is_edit;
    logic         w_next_is_edit;
    field_t       w_field;

    // Datapath
    logic [23:0]   r_edit;
    logic [23:0]   w_edit_next;
    logic          r_imp;
    logic          r_blink;
    logic [BW-1:0] r_blink_cnt;

    // Field views of the edit register
    logic [FIELD_W-1:0] w_hour;
    logic [FIELD_W-1:0] w_min;
    logic [FIELD_W-1:0] w_sec;

    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_mode (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (btn_mode),
        .press   (w_mode_p)
    );

    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_up (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (btn_up),
        .press   (w_up_p)
    );

    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_down (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (btn_down),
        .press   (w_down_p)
    );

    // Mode wins over up/down; up together with down cancels out
    assign w_inc = w_up_p   && !w_down_p && !w_mode_p;
    assign w_dec = w_down_p && !w_up_p   && !w_mode_p;

    assign w_hour = r_edit[HOUR_LSB +: FIELD_W];
    assign w_min  = r_edit[MIN_LSB  +: FIELD_W];
    assign w_sec  = r_edit[SEC_LSB  +: FIELD_W];

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic: mode walks hour -> min -> sec -> commit -> idle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_mode_p) w_next_state = S_EDIT_HOUR;
            S_EDIT_HOUR: if (w_mode_p) w_next_state = S_EDIT_MIN;
            S_EDIT_MIN:  if (w_mode_p) w_next_state = S_EDIT_SEC;
            S_EDIT_SEC:  if (w_mode_p) w_next_state = S_COMMIT;
            S_COMMIT:    w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_is_edit = 1'b0;
        w_field   = F_HOUR;
        case (r_state)
            S_EDIT_HOUR: begin w_is_edit = 1'b1; w_field = F_HOUR; end
            S_EDIT_MIN:  begin w_is_edit = 1'b1; w_field = F_MIN;  end
            S_EDIT_SEC:  begin w_is_edit = 1'b1; w_field = F_SEC;  end
            default:     begin w_is_edit = 1'b0; w_field = F_HOUR; end
        endcase
    end

    assign w_next_is_edit = (w_next_state == S_EDIT_HOUR) ||
                            (w_next_state == S_EDIT_MIN)  ||
                            (w_next_state == S_EDIT_SEC);

    // Edit register next value: capture in IDLE, per-field wrap in EDIT states
    always_comb begin
        w_edit_next = r_edit;
        case (r_state)
            S_IDLE: begin
                if (w_mode_p) begin
                    w_edit_next[HOUR_LSB +: FIELD_W] = clamp_field(time_in[HOUR_LSB +: FIELD_W], HOUR_MAX);
                    w_edit_next[MIN_LSB  +: FIELD_W] = clamp_field(time_in[MIN_LSB  +: FIELD_W], MIN_MAX);
                    w_edit_next[SEC_LSB  +: FIELD_W] = clamp_field(time_in[SEC_LSB  +: FIELD_W], SEC_MAX);
                end
            end
            S_EDIT_HOUR: begin
                if (w_inc)      w_edit_next[HOUR_LSB +: FIELD_W] = inc_wrap(w_hour, HOUR_MAX);
                else if (w_dec) w_edit_next[HOUR_LSB +: FIELD_W] = dec_wrap(w_hour, HOUR_MAX);
            end
            S_EDIT_MIN: begin
                if (w_inc)      w_edit_next[MIN_LSB +: FIELD_W] = inc_wrap(w_min, MIN_MAX);
                else if (w_dec) w_edit_next[MIN_LSB +: FIELD_W] = dec_wrap(w_min, MIN_MAX);
            end
            S_EDIT_SEC: begin
                if (w_inc)      w_edit_next[SEC_LSB +: FIELD_W] = inc_wrap(w_sec, SEC_MAX);
                else if (w_dec) w_edit_next[SEC_LSB +: FIELD_W] = dec_wrap(w_sec, SEC_MAX);
            end
            default: w_edit_next = r_edit;
        endcase
    end

    // Edit register; keeps the committed value while idle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_edit <= '0;
        else        r_edit <= w_edit_next;
    end

    // Registered load strobe, high exactly during the COMMIT cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_imp <= 1'b0;
        else        r_imp <= (w_next_state == S_COMMIT);
    end

    // Blink generator: restarts high on every EDIT entry, toggles each BLINK_DIV cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
        end else if (w_next_is_edit && (w_next_state != r_state)) begin
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
        end else if (!w_is_edit) begin
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink     <= ~r_blink;
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    assign setup_data  = r_edit;
    assign setup_imp   = r_imp;
    assign edit_active = w_is_edit;
    assign edit_field  = w_field;
    assign blink       = r_blink && w_is_edit;
    assign dbg_state   = r_state;

endmodule
